// File: rtl/power_down_sequencer.sv
// Board rail sequencer: ramps rails on in order once the regulator reports power good, and
// removes them in reverse order on request, long button press, kill or loss of power_on.
module power_down_sequencer #(
    parameter int NUM_RAILS       = 4,
    parameter int RAIL_GAP        = 33000,
    parameter int DEBOUNCE_CYCLES = 330000,
    parameter int HOLD_CYCLES     = 132000000,
    parameter int ACK_TIMEOUT     = 33000000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 power_on,
    input  logic                 pub_n,
    input  logic                 soft_shutdown,
    input  logic                 kill,
    input  logic                 shutdown_ack,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 vcc_good,
    output logic                 shutdown_req,
    output logic                 shutdown_timeout,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_RUN       = 3'd2,
        S_REQ       = 3'd3,
        S_RAMP_DOWN = 3'd4
    } state_t;

    localparam int SEQ_MAX = (RAIL_GAP > ACK_TIMEOUT) ? RAIL_GAP : ACK_TIMEOUT;
    localparam int CW      = $clog2(SEQ_MAX + 1);
    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW      = $clog2(HOLD_CYCLES + 1);

    state_t        cur;
    logic          armed;
    logic [CW-1:0] cnt;

    logic [1:0]    sync;
    logic          pressed;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          fired;
    logic          long_press;

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    assign state = cur;

    // Button path: synchronise, debounce, then time the debounced press.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync       <= 2'b11;
            pressed    <= 1'b0;
            db_cnt     <= '0;
            hold_cnt   <= '0;
            fired      <= 1'b0;
            long_press <= 1'b0;
        end else begin
            sync       <= {sync[0], pub_n};
            long_press <= 1'b0;
            if (!sync[1] != pressed) begin
                if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    pressed <= !sync[1];
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
            // hold_cnt parks at its terminal value; fired blocks re-triggering until release
            if (pressed) begin
                if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    if (!fired) begin
                        long_press <= 1'b1;
                        fired      <= 1'b1;
                    end
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end else begin
                hold_cnt <= '0;
                fired    <= 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cur              <= S_OFF;
            rail_en          <= '0;
            vcc_good         <= 1'b0;
            shutdown_req     <= 1'b0;
            shutdown_timeout <= 1'b0;
            armed            <= 1'b1;
            cnt              <= '0;
        end else begin
            case (cur)
                S_OFF: begin
                    if (!power_on) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        cur              <= S_RAMP_UP;
                        rail_en          <= NUM_RAILS'(1);
                        shutdown_timeout <= 1'b0;
                        cnt              <= '0;
                    end
                end
                S_RAMP_UP: begin
                    if (kill || !power_on) begin
                        cur <= S_RAMP_DOWN;
                        cnt <= '0;
                    end else if (cnt == CW'(RAIL_GAP - 1)) begin
                        cnt <= '0;
                        if (rail_en[NUM_RAILS-1]) begin
                            vcc_good <= 1'b1;
                            cur      <= S_RUN;
                        end else begin
                            rail_en <= (rail_en << 1) | NUM_RAILS'(1);
                        end
                    end else begin
                        cnt <= inc(cnt);
                    end
                end
                S_RUN: begin
                    if (kill || !power_on) begin
                        cur      <= S_RAMP_DOWN;
                        vcc_good <= 1'b0;
                        cnt      <= '0;
                    end else if (soft_shutdown || long_press) begin
                        cur          <= S_REQ;
                        shutdown_req <= 1'b1;
                        cnt          <= '0;
                    end
                end
                S_REQ: begin
                    // ack is checked before the timeout so a same-cycle ack leaves the flag clear
                    if (kill || !power_on || shutdown_ack || cnt == CW'(ACK_TIMEOUT - 1)) begin
                        cur          <= S_RAMP_DOWN;
                        vcc_good     <= 1'b0;
                        shutdown_req <= 1'b0;
                        cnt          <= '0;
                        if (power_on && !kill && !shutdown_ack)
                            shutdown_timeout <= 1'b1;
                    end else begin
                        cnt <= inc(cnt);
                    end
                end
                S_RAMP_DOWN: begin
                    if (rail_en == '0) begin
                        cur   <= S_OFF;
                        armed <= 1'b0;
                    end else if (cnt == CW'(RAIL_GAP - 1)) begin
                        cnt     <= '0;
                        rail_en <= rail_en >> 1;
                        if ((rail_en >> 1) == '0) begin
                            cur   <= S_OFF;
                            armed <= 1'b0;
                        end
                    end else begin
                        cnt <= inc(cnt);
                    end
                end
                default: cur <= S_OFF;
            endcase
        end
    end

endmodule
